// File: rtl/led_status_mapper_pkg.sv
// Shared definitions for the bar-LED status path.
//   ledframe_t   : frame as [row][colour][column]
//   LED_ROW_*    : row assignment of the bar display
//   LED_GREEN/RED: colour plane index inside a row
package led_status_mapper_pkg;

    localparam int NUMBER_OF_MOTORS_PER_FIBER = 16;

    typedef logic [3:0][1:0][15:0] ledframe_t;

    localparam int LED_ROW_SWA   = 0;
    localparam int LED_ROW_SWB   = 1;
    localparam int LED_ROW_ACT   = 2;
    localparam int LED_ROW_FAULT = 3;

    localparam int LED_GREEN = 0;
    localparam int LED_RED   = 1;

endpackage

// File: rtl/led_status_mapper_if.sv
// Link between the status mapper and the tlc5920 bar-LED driver.
//   frame_done_i : driver -> mapper, one-cycle pulse at the end of a scan
//   ledData_ob   : mapper -> driver, frame currently displayed
//   updated_o    : mapper -> driver, one-cycle pulse on the cycle ledData_ob changes
// Handshake: there is no back-pressure. The mapper only changes ledData_ob
// on a load (frame_done_i or timeout) and marks that cycle with updated_o;
// ledData_ob is stable on every other cycle.
interface led_status_mapper_if;
    import led_status_mapper_pkg::*;

    logic      frame_done_i;
    ledframe_t ledData_ob;
    logic      updated_o;

    // mapper side
    modport master (
        input  frame_done_i,
        output ledData_ob,
        output updated_o
    );

    // driver side
    modport slave (
        output frame_done_i,
        input  ledData_ob,
        input  updated_o
    );

endinterface

// File: rtl/led_status_mapper_pulse_stretcher.sv
// Keeps a single-cycle step pulse visible for g_stretch_ticks ticks.
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   rise_i          : step rising edge, reloads the full stretch
//   tick_i          : timebase tick, decrements a running stretch
//   active_o        : high while the stretch count is nonzero
module led_status_mapper_pulse_stretcher #(
    parameter int g_stretch_ticks = 50
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic rise_i,
    input  logic tick_i,
    output logic active_o
);

    localparam int CW = $clog2(g_stretch_ticks + 1);

    logic [CW-1:0] count;

    // A reload takes priority over a coincident tick; zero holds at zero.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count <= '0;
        end else if (rise_i) begin
            count <= CW'(g_stretch_ticks);
        end else if (tick_i && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign active_o = (count != '0);

endmodule

// File: rtl/led_status_mapper.sv
// Builds the 4-row x 2-colour x 16-column bar-LED frame from live motor status
// and hands it to the tlc5920 driver, changing it only at scan boundaries.
//   clk_i, reset_ni : 100 MHz clock, asynchronous active-low reset
//   sw_a_ib16       : raw end-switch A per motor (asynchronous)
//   sw_b_ib16       : raw end-switch B per motor (asynchronous)
//   pfail_ib16      : raw power-fail per motor, active high (asynchronous)
//   step_ib16       : step pulses per motor (clk_i domain)
//   deact_ib16      : motor-deactivated flags (clk_i domain)
//   lamp_test_i     : forces every LED on
//   led_bus         : frame_done_i in, ledData_ob / updated_o out
// Rows: 0 switch A, 1 switch B, 2 step activity / deactivated, 3 power fail.
module led_status_mapper
    import led_status_mapper_pkg::*;
#(
    parameter int g_motors        = NUMBER_OF_MOTORS_PER_FIBER,
    parameter int g_tick_div      = 100000,
    parameter int g_stretch_ticks = 50,
    parameter int g_blink_ticks   = 250,
    parameter int g_frame_timeout = 2000000,
    parameter int g_sw_active_low = 1
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic [g_motors-1:0] sw_a_ib16,
    input  logic [g_motors-1:0] sw_b_ib16,
    input  logic [g_motors-1:0] pfail_ib16,
    input  logic [g_motors-1:0] step_ib16,
    input  logic [g_motors-1:0] deact_ib16,
    input  logic                lamp_test_i,
    led_status_mapper_if.master led_bus
);

    localparam int TW = (g_tick_div > 1) ? $clog2(g_tick_div) : 1;
    localparam int BW = (g_blink_ticks > 1) ? $clog2(g_blink_ticks) : 1;
    localparam int OW = $clog2(g_frame_timeout + 1);

    // Raw pin level of a switch that is not hit; used as synchroniser preset
    // and as the XOR mask that turns pin level into "switch hit".
    localparam logic [g_motors-1:0] SW_IDLE = {g_motors{(g_sw_active_low != 0)}};

    logic [g_motors-1:0] sw_a_s1, sw_a_s2;
    logic [g_motors-1:0] sw_b_s1, sw_b_s2;
    logic [g_motors-1:0] pf_s1, pf_s2;
    logic [g_motors-1:0] step_q;

    logic [g_motors-1:0] sw_a, sw_b, rise, act;

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [BW-1:0] blink_cnt;
    logic          blink;
    logic [OW-1:0] to_cnt;
    logic          to_hit;
    logic          load;

    ledframe_t next_frame;

    // ---------------------------------------------------------------
    // Input synchronisation and step edge detection
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sw_a_s1 <= SW_IDLE;
            sw_a_s2 <= SW_IDLE;
            sw_b_s1 <= SW_IDLE;
            sw_b_s2 <= SW_IDLE;
            pf_s1   <= '0;
            pf_s2   <= '0;
            step_q  <= '0;
        end else begin
            sw_a_s1 <= sw_a_ib16;
            sw_a_s2 <= sw_a_s1;
            sw_b_s1 <= sw_b_ib16;
            sw_b_s2 <= sw_b_s1;
            pf_s1   <= pfail_ib16;
            pf_s2   <= pf_s1;
            step_q  <= step_ib16;
        end
    end

    assign sw_a = sw_a_s2 ^ SW_IDLE;
    assign sw_b = sw_b_s2 ^ SW_IDLE;
    assign rise = step_ib16 & ~step_q;

    // ---------------------------------------------------------------
    // Timebase: tick prescaler and blink phase
    // ---------------------------------------------------------------
    assign tick = (tick_cnt == TW'(g_tick_div - 1));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BW'(g_blink_ticks - 1)) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    // ---------------------------------------------------------------
    // Per-motor activity stretchers
    // ---------------------------------------------------------------
    for (genvar m = 0; m < g_motors; m++) begin : g_stretch
        led_status_mapper_pulse_stretcher #(
            .g_stretch_ticks(g_stretch_ticks)
        ) u_stretch (
            .clk_i   (clk_i),
            .reset_ni(reset_ni),
            .rise_i  (rise[m]),
            .tick_i  (tick),
            .active_o(act[m])
        );
    end

    // ---------------------------------------------------------------
    // Next-frame map
    // ---------------------------------------------------------------
    always_comb begin
        next_frame = '0;
        for (int c = 0; c < g_motors; c++) begin
            next_frame[LED_ROW_SWA][LED_GREEN][c]   = sw_a[c];
            next_frame[LED_ROW_SWB][LED_GREEN][c]   = sw_b[c];
            next_frame[LED_ROW_ACT][LED_GREEN][c]   = act[c] & ~deact_ib16[c];
            next_frame[LED_ROW_ACT][LED_RED][c]     = deact_ib16[c];
            next_frame[LED_ROW_FAULT][LED_GREEN][c] = ~pf_s2[c];
            next_frame[LED_ROW_FAULT][LED_RED][c]   = pf_s2[c] & blink;
        end
        if (lamp_test_i) begin
            next_frame = '1;
        end
    end

    // ---------------------------------------------------------------
    // Load control: scan boundary, or a forced load if the driver goes quiet
    // ---------------------------------------------------------------
    assign to_hit = (to_cnt == OW'(g_frame_timeout));
    assign load   = led_bus.frame_done_i | to_hit;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            to_cnt <= '0;
        end else if (load) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + OW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            led_bus.ledData_ob <= '0;
            led_bus.updated_o  <= 1'b0;
        end else begin
            led_bus.updated_o <= load;
            if (load) begin
                led_bus.ledData_ob <= next_frame;
            end
        end
    end

endmodule
